// File: rtl/reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_pkg
// Shared types and helpers for the reg_bank_seq capture bank.
//   state_e     : top-level FSM states (RUN = normal loading, CLR = clear sweep)
//   MODE_*      : update-policy encodings of the 2-bit mode input
//                 (encoding 3 behaves like MODE_HOLD)
//   get_slice() : extracts a w-bit field at position idx from a packed vector
//                 holding up to SLICE_MAX bits
// -----------------------------------------------------------------------------
package reg_bank_pkg;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_CLR = 1'b1
    } state_e;

    localparam logic [1:0] MODE_PASS    = 2'd0;
    localparam logic [1:0] MODE_CAPTURE = 2'd1;
    localparam logic [1:0] MODE_HOLD    = 2'd2;

    // Widest packed vector get_slice() can address; NCH*W must not exceed it.
    localparam int SLICE_MAX = 256;

    // Returns field idx of width w, zero-extended to SLICE_MAX bits.
    // Callers cast the result down to their own field width.
    function automatic logic [SLICE_MAX-1:0] get_slice(
        input logic [SLICE_MAX-1:0] vec,
        input int                   idx,
        input int                   w
    );
        logic [SLICE_MAX-1:0] mask;
        mask = '0;
        for (int b = 0; b < SLICE_MAX; b++) begin
            if (b < w) mask[b] = 1'b1;
        end
        return (vec >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/reg_bank_chan.sv
// -----------------------------------------------------------------------------
// reg_bank_chan
// One channel of the capture bank: a W-bit register with a per-instance reset
// value and a registered strobe that pulses the cycle after the stored value
// actually changes.
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset (restores RST_VAL, clears chg)
//   load_i     : load load_val_i into the register this cycle
//   load_val_i : value to load
//   q_o        : registered channel value
//   chg_o      : registered change strobe
// -----------------------------------------------------------------------------
module reg_bank_chan #(
    parameter int          W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] q_o,
    output logic         chg_o
);

    logic [W-1:0] val_q, val_d;
    logic         chg_q, chg_d;

    always_comb begin
        val_d = val_q;
        chg_d = 1'b0;
        if (load_i) begin
            val_d = load_val_i;
            // Reloading the value already held is not a change.
            chg_d = (load_val_i != val_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            val_q <= RST_VAL;
            chg_q <= 1'b0;
        end else begin
            val_q <= val_d;
            chg_q <= chg_d;
        end
    end

    assign q_o   = val_q;
    assign chg_o = chg_q;

endmodule

// File: rtl/reg_bank_seq.sv
// -----------------------------------------------------------------------------
// reg_bank_seq
// NCH-channel registered capture bank with selectable update policy and a
// channel-by-channel soft clear back to RST_VAL.
// Parameters:
//   NCH     : number of channels (>= 1)
//   W       : bits per channel (>= 1)
//   RST_VAL : reset / soft-clear value, channel i in bits [i*W +: W]
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, overrides everything
//   mode     : 0 PASS, 1 CAPTURE, 2/3 HOLD
//   in_data  : candidate values, packed per channel
//   in_vld   : capture qualifier (CAPTURE mode only)
//   soft_clr : request a sequenced restore of RST_VAL
//   out_data : registered channel values
//   out_vld  : pulse the cycle after any RUN-state load
//   chg      : per-channel pulse the cycle after that channel changed
//   busy     : high while the clear sweep is running
// -----------------------------------------------------------------------------
module reg_bank_seq
    import reg_bank_pkg::*;
#(
    parameter int                 NCH     = 3,
    parameter int                 W       = 1,
    parameter logic [NCH*W-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [NCH*W-1:0] in_data,
    input  logic             in_vld,
    input  logic             soft_clr,
    output logic [NCH*W-1:0] out_data,
    output logic             out_vld,
    output logic [NCH-1:0]   chg,
    output logic             busy
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              vld_q, vld_d;
    logic              busy_q, busy_d;
    logic              load_all;
    logic [NCH-1:0]    clr_sel;
    logic [SLICE_MAX-1:0] in_ext;

    assign in_ext = SLICE_MAX'(in_data);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        vld_d    = 1'b0;
        load_all = 1'b0;
        clr_sel  = '0;

        unique case (state_q)
            ST_RUN: begin
                if (soft_clr) begin
                    // The clear request pre-empts any load in the same cycle.
                    state_d = ST_CLR;
                    idx_d   = '0;
                end else begin
                    case (mode)
                        MODE_PASS: begin
                            load_all = 1'b1;
                            vld_d    = 1'b1;
                        end
                        MODE_CAPTURE: begin
                            load_all = in_vld;
                            vld_d    = in_vld;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CLR: begin
                for (int i = 0; i < NCH; i++) begin
                    clr_sel[i] = (idx_q == IW'(i));
                end
                if (idx_q == IW'(NCH - 1)) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                idx_d   = '0;
            end
        endcase

        // Registering the next state makes busy line up with the CLR cycles.
        busy_d = (state_d == ST_CLR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        localparam logic [W-1:0] CH_RST = RST_VAL[i*W +: W];

        logic         ch_load;
        logic [W-1:0] ch_val;

        assign ch_load = load_all | clr_sel[i];
        assign ch_val  = clr_sel[i] ? CH_RST : W'(get_slice(in_ext, i, W));

        reg_bank_chan #(
            .W       (W),
            .RST_VAL (CH_RST)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .load_i     (ch_load),
            .load_val_i (ch_val),
            .q_o        (out_data[i*W +: W]),
            .chg_o      (chg[i])
        );
    end

    assign out_vld = vld_q;
    assign busy    = busy_q;

endmodule

// File: doc/reg_bank_seq.md
# reg_bank_seq

Parametrised multi-channel registered capture bank: NCH channels of W bits each, loaded from a flat input bus under a selectable update mode, with per-channel reset values and a sequenced soft clear. It sits between raw control inputs and downstream consumers that need registered, reset-defined values plus per-channel change strobes. It is the generalised successor of the fixed three-flop reset/capture register: width, channel count, reset values and update policy are parameters or run-time inputs.

## Interface
- NCH, default 3: number of channels, at least 1.
- W, default 1: bits per channel, at least 1.
- RST_VAL, default all zeros, NCH*W bits: reset and soft-clear value. Channel i uses bits [i*W +: W].
- IW, derived as max(1, clog2(NCH)): sweep index width. Not user-set.

- clk, input, 1: sole clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- mode, input, 2: update policy. 0 = PASS, 1 = CAPTURE, 2 and 3 = HOLD.
- in_data, input, NCH*W: candidate values, packed per channel.
- in_vld, input, 1: capture qualifier, used in CAPTURE mode only.
- soft_clr, input, 1: single-cycle request to restore RST_VAL channel by channel.
- out_data, output, NCH*W: registered channel values.
- out_vld, output, 1: registered pulse, high the cycle after any RUN-state load.
- chg, output, NCH: registered per-channel pulse, high the cycle after that channel's value changed.
- busy, output, 1: high while the clear sweep is in progress.

## Operation
- FSM states are RUN and CLR. Reset goes to RUN.
- Reset, sampled at a clk edge:
  - out_data = RST_VAL, out_vld = 0, chg = 0, busy = 0.
  - Sweep index = 0, state = RUN.
  - Reset overrides every other input.
- RUN, by mode:
  - PASS: all channels load in_data every cycle. out_vld = 1 the next cycle.
  - CAPTURE: all channels load in_data only when in_vld = 1. out_vld follows in_vld, delayed one cycle.
  - HOLD: no load. out_vld = 0.
- RUN with soft_clr = 1:
  - Go to CLR and set index = 0.
  - No load happens in that cycle, whatever mode and in_vld are. soft_clr wins.
- CLR:
  - Each cycle, channel[index] loads its RST_VAL slice and index increments.
  - When index = NCH-1, load that channel, return to RUN and reset index to 0.
- CLR input handling:
  - in_data, in_vld and mode are ignored.
  - soft_clr is ignored; the sweep does not restart.
  - Channels not yet swept keep their values.
- chg[i] = 1 the cycle after channel i's stored value changes, in any state. A load of an identical value gives chg[i] = 0.
- busy is a registered copy of (state == CLR).

## Timing
- Latency is one cycle from in_data and in_vld to out_data and out_vld.
- A soft_clr at cycle t produces:
  - busy high from t+1 to t+NCH.
  - Channel k restored at the edge ending cycle t+1+k.
  - Normal mode operation from cycle t+NCH+1.
- NCH = 1: the CLR phase lasts one cycle and busy is high for one cycle.
- A mode change takes effect on the same edge it is sampled, in RUN only.
- Reset asserted mid-sweep aborts the sweep, restores all channels at once and leaves busy = 0 the next cycle.
- out_vld is never high during CLR or in the cycle right after the soft_clr request.

## Structure
- Package reg_bank_pkg holds:
  - the state enum (RUN, CLR);
  - mode constants MODE_PASS = 0, MODE_CAPTURE = 1, MODE_HOLD = 2;
  - a function that extracts a W-bit slice from a packed NCH*W vector.
- Sub-module reg_bank_chan is instantiated NCH times. Each instance holds:
  - one W-bit register with a reset value parameter;
  - load and load-value inputs;
  - a registered change strobe.
- The top level holds the FSM, the sweep counter and out_vld generation.

## Test plan
- Reset with NCH=3, W=4, RST_VAL=12'hC00:
  - out_data = 12'hC00, busy = 0, out_vld = 0, chg = 0.
- PASS with in_data 12'h123 then 12'h124:
  - out_data = 12'h123 then 12'h124, out_vld stays high.
  - chg = 3'b111 after the first load, then 3'b001.
- CAPTURE with in_vld low for 2 cycles, then high with in_data 12'hABC:
  - out_data unchanged for 2 cycles, then 12'hABC.
  - out_vld pulses once.
- HOLD with in_data toggling:
  - out_data constant, out_vld = 0, chg = 0.
- soft_clr pulse from out_data 12'hABC:
  - Successive values 12'hABC, 12'hAB0, 12'hA00, 12'hC00.
  - busy high exactly 3 cycles.
  - A second soft_clr mid-sweep is ignored.
  - A simultaneous in_vld produces no capture.
- reset asserted at the second sweep cycle:
  - Next cycle out_data = 12'hC00, busy = 0, state RUN.
  - PASS resumes immediately after.
